// File: rtl/credential_check_sequencer_if.sv
// Bus bundle between the keypad access controller and the credential backend.
// master: the access controller / config writer; slave: the credential sequencer.
interface credential_check_sequencer_if;
    logic        id_req;
    logic        pwd_req;
    logic        reconfig;
    logic [15:0] id_in;
    logic [15:0] pwd_in;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_id;
    logic [15:0] cfg_pwd;
    logic        cfg_ack;
    logic        id_checked;
    logic        pass_checked;
    logic        id_fail;
    logic        pwd_fail;
    logic        lockout;
    logic [3:0]  fail_count;
    logic [2:0]  user_idx;
    logic        busy;

    modport master (
        output id_req, pwd_req, reconfig, id_in, pwd_in,
        output cfg_we, cfg_idx, cfg_id, cfg_pwd,
        input  cfg_ack, id_checked, pass_checked, id_fail, pwd_fail,
        input  lockout, fail_count, user_idx, busy
    );

    modport slave (
        input  id_req, pwd_req, reconfig, id_in, pwd_in,
        input  cfg_we, cfg_idx, cfg_id, cfg_pwd,
        output cfg_ack, id_checked, pass_checked, id_fail, pwd_fail,
        output lockout, fail_count, user_idx, busy
    );
endinterface

// File: rtl/credential_check_sequencer.sv
// Credential backend: small ID/password table, sequential ID scan, password
// compare, consecutive-failure counting and timed lockout.
module credential_check_sequencer #(
    parameter int NUM_USERS   = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 50_000_000,
    parameter int LOCK_W      = 26
) (
    input  logic clk,
    input  logic rst,
    credential_check_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ID_SCAN, ID_WAIT, PWD_CMP, GRANTED, LOCKED} state_t;

    localparam logic [2:0]        LAST_IDX    = 3'(NUM_USERS - 1);
    localparam logic [3:0]        NUM_USERS_W = 4'(NUM_USERS);
    localparam logic [3:0]        MAX_FAILS_W = 4'(MAX_FAILS);
    localparam logic [LOCK_W-1:0] LOCK_LOAD   = LOCK_W'(LOCK_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [2:0]          scan_idx_reg, scan_idx_next;
    logic [15:0]         id_latch_reg, id_latch_next;
    logic [15:0]         pwd_latch_reg, pwd_latch_next;
    logic [LOCK_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [3:0]          fail_count_reg, fail_count_next;
    logic [2:0]          user_idx_reg, user_idx_next;
    logic                id_checked_reg, id_checked_next;
    logic                pass_checked_reg, pass_checked_next;
    logic                id_fail_reg, id_fail_next;
    logic                pwd_fail_reg, pwd_fail_next;
    logic                cfg_ack_reg, cfg_ack_next;
    logic                id_prev_reg, pwd_prev_reg;

    // Table is sized to the full 3-bit index space; entries at or above
    // NUM_USERS are never written, so their valid bits stay clear.
    logic [15:0] tbl_id  [0:7];
    logic [15:0] tbl_pwd [0:7];
    logic [7:0]  tbl_valid;
    logic        tbl_we;

    logic        id_edge, pwd_edge, idx_ok, scan_hit, pwd_hit;
    logic [3:0]  fail_inc;
    logic        fail_at_max;

    assign id_edge     = bus.id_req & ~id_prev_reg;
    assign pwd_edge    = bus.pwd_req & ~pwd_prev_reg;
    assign idx_ok      = {1'b0, bus.cfg_idx} < NUM_USERS_W;
    assign scan_hit    = tbl_valid[scan_idx_reg] && (tbl_id[scan_idx_reg] == id_latch_reg);
    assign pwd_hit     = tbl_pwd[user_idx_reg] == pwd_latch_reg;
    assign fail_inc    = (fail_count_reg >= MAX_FAILS_W) ? fail_count_reg : fail_count_reg + 4'd1;
    assign fail_at_max = fail_inc >= MAX_FAILS_W;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_entry
            logic        valid_reg;
            logic [15:0] id_reg;
            logic [15:0] pwd_reg;
            // Per-entry storage: valid cleared by reset, data written on accepted config beats.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_reg <= 1'b0;
                end else if (tbl_we && (bus.cfg_idx == 3'(gi))) begin
                    valid_reg <= 1'b1;
                    id_reg    <= bus.cfg_id;
                    pwd_reg   <= bus.cfg_pwd;
                end
            end
            assign tbl_valid[gi] = valid_reg;
            assign tbl_id[gi]    = id_reg;
            assign tbl_pwd[gi]   = pwd_reg;
        end
    endgenerate

    // State and registered outputs; edge-detect history follows the request levels every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            scan_idx_reg     <= '0;
            id_latch_reg     <= '0;
            pwd_latch_reg    <= '0;
            lock_cnt_reg     <= '0;
            fail_count_reg   <= '0;
            user_idx_reg     <= '0;
            id_checked_reg   <= 1'b0;
            pass_checked_reg <= 1'b0;
            id_fail_reg      <= 1'b0;
            pwd_fail_reg     <= 1'b0;
            cfg_ack_reg      <= 1'b0;
            id_prev_reg      <= 1'b0;
            pwd_prev_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            scan_idx_reg     <= scan_idx_next;
            id_latch_reg     <= id_latch_next;
            pwd_latch_reg    <= pwd_latch_next;
            lock_cnt_reg     <= lock_cnt_next;
            fail_count_reg   <= fail_count_next;
            user_idx_reg     <= user_idx_next;
            id_checked_reg   <= id_checked_next;
            pass_checked_reg <= pass_checked_next;
            id_fail_reg      <= id_fail_next;
            pwd_fail_reg     <= pwd_fail_next;
            cfg_ack_reg      <= cfg_ack_next;
            id_prev_reg      <= bus.id_req;
            pwd_prev_reg     <= bus.pwd_req;
        end
    end

    // Next-state logic: reconfig beats any same-cycle compare result; LOCKED ignores all inputs.
    always_comb begin
        state_next        = state_reg;
        scan_idx_next     = scan_idx_reg;
        id_latch_next     = id_latch_reg;
        pwd_latch_next    = pwd_latch_reg;
        lock_cnt_next     = lock_cnt_reg;
        fail_count_next   = fail_count_reg;
        user_idx_next     = user_idx_reg;
        id_checked_next   = id_checked_reg;
        pass_checked_next = pass_checked_reg;
        id_fail_next      = 1'b0;
        pwd_fail_next     = 1'b0;
        cfg_ack_next      = 1'b0;
        tbl_we            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (id_edge) begin
                    id_latch_next = bus.id_in;
                    scan_idx_next = '0;
                    state_next    = ID_SCAN;
                end else if (bus.cfg_we && idx_ok) begin
                    tbl_we       = 1'b1;
                    cfg_ack_next = 1'b1;
                end
            end
            ID_SCAN: begin
                if (bus.reconfig) begin
                    state_next = IDLE;
                end else if (scan_hit) begin
                    id_checked_next = 1'b1;
                    user_idx_next   = scan_idx_reg;
                    state_next      = ID_WAIT;
                end else if (scan_idx_reg == LAST_IDX) begin
                    id_fail_next    = 1'b1;
                    fail_count_next = fail_inc;
                    if (fail_at_max) begin
                        lock_cnt_next = LOCK_LOAD;
                        state_next    = LOCKED;
                    end else begin
                        state_next    = IDLE;
                    end
                end else begin
                    scan_idx_next = scan_idx_reg + 3'd1;
                end
            end
            ID_WAIT: begin
                if (bus.reconfig) begin
                    state_next = IDLE;
                end else if (pwd_edge) begin
                    pwd_latch_next = bus.pwd_in;
                    state_next     = PWD_CMP;
                end
            end
            PWD_CMP: begin
                if (bus.reconfig) begin
                    state_next = IDLE;
                end else if (pwd_hit) begin
                    pass_checked_next = 1'b1;
                    fail_count_next   = '0;
                    state_next        = GRANTED;
                end else begin
                    pwd_fail_next   = 1'b1;
                    fail_count_next = fail_inc;
                    if (fail_at_max) begin
                        lock_cnt_next = LOCK_LOAD;
                        state_next    = LOCKED;
                    end else begin
                        state_next    = ID_WAIT;
                    end
                end
            end
            GRANTED: begin
                if (bus.reconfig) begin
                    state_next = IDLE;
                end
            end
            LOCKED: begin
                if (lock_cnt_reg == '0) begin
                    fail_count_next = '0;
                    state_next      = IDLE;
                end else begin
                    lock_cnt_next = lock_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Leaving a session (to IDLE or LOCKED) drops the match flags.
        if ((state_next == IDLE || state_next == LOCKED) && state_reg != IDLE) begin
            id_checked_next   = 1'b0;
            pass_checked_next = 1'b0;
            user_idx_next     = '0;
        end
    end

    assign bus.cfg_ack      = cfg_ack_reg;
    assign bus.id_checked   = id_checked_reg;
    assign bus.pass_checked = pass_checked_reg;
    assign bus.id_fail      = id_fail_reg;
    assign bus.pwd_fail     = pwd_fail_reg;
    assign bus.lockout      = (state_reg == LOCKED);
    assign bus.fail_count   = fail_count_reg;
    assign bus.user_idx     = user_idx_reg;
    assign bus.busy         = (state_reg == ID_SCAN) || (state_reg == PWD_CMP);

endmodule

// File: tb/tb_credential_check_sequencer.sv
// Directed bench for credential_check_sequencer: a cycle-by-cycle vector table
// plus hand-written sequences for lockout, scan misses, collisions and reset.
module tb_credential_check_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    credential_check_sequencer_if bus_if();

    credential_check_sequencer #(
        .NUM_USERS  (4),
        .MAX_FAILS  (3),
        .LOCK_CYCLES(20),
        .LOCK_W     (26)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // One cycle of stimulus and the outputs expected right after that cycle's edge.
    // exp packing: {cfg_ack, id_checked, pass_checked, id_fail, pwd_fail, lockout, busy, fail_count[3:0], user_idx[2:0]}
    typedef struct {
        string       nm;
        logic        rst_n;
        logic        id_req;
        logic [15:0] id_in;
        logic        pwd_req;
        logic [15:0] pwd_in;
        logic        reconfig;
        logic        cfg_we;
        logic [2:0]  cfg_idx;
        logic [15:0] cfg_id;
        logic [15:0] cfg_pwd;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input string nm, input logic r, input logic ir, input logic [15:0] iid,
                                input logic pr, input logic [15:0] ipw, input logic rc, input logic cw,
                                input logic [2:0] ci, input logic [15:0] cid, input logic [15:0] cpw,
                                input logic ack, input logic idc, input logic pc, input logic idf,
                                input logic pwf, input logic lk, input logic bsy,
                                input logic [3:0] fc, input logic [2:0] ui);
        vec_t v;
        v.nm = nm; v.rst_n = r; v.id_req = ir; v.id_in = iid; v.pwd_req = pr; v.pwd_in = ipw;
        v.reconfig = rc; v.cfg_we = cw; v.cfg_idx = ci; v.cfg_id = cid; v.cfg_pwd = cpw;
        v.exp = {ack, idc, pc, idf, pwf, lk, bsy, fc, ui};
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [13:0] got;
        @(negedge clk);
        rst             = v.rst_n;
        bus_if.id_req   = v.id_req;
        bus_if.id_in    = v.id_in;
        bus_if.pwd_req  = v.pwd_req;
        bus_if.pwd_in   = v.pwd_in;
        bus_if.reconfig = v.reconfig;
        bus_if.cfg_we   = v.cfg_we;
        bus_if.cfg_idx  = v.cfg_idx;
        bus_if.cfg_id   = v.cfg_id;
        bus_if.cfg_pwd  = v.cfg_pwd;
        @(posedge clk);
        #1;
        got = {bus_if.cfg_ack, bus_if.id_checked, bus_if.pass_checked, bus_if.id_fail,
               bus_if.pwd_fail, bus_if.lockout, bus_if.busy, bus_if.fail_count, bus_if.user_idx};
        checks++;
        if (got !== v.exp) begin
            failures++;
            $display("FAIL %s: outputs got=%b required=%b (ack,idc,pc,idf,pwf,lk,busy,fc[4],ui[3])",
                     v.nm, got, v.exp);
        end else begin
            $display("ok   %s: outputs=%b", v.nm, got);
        end
    endtask

    // Lookup of an ID that is in no valid entry: busy for four scan cycles, id_fail on the fifth.
    task automatic scan_miss(input string nm, input logic [15:0] id, input logic [3:0] fc0);
        run_vec(mk({nm, "_req"},   1, 1, id, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, fc0, 0));
        run_vec(mk({nm, "_scan0"}, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, fc0, 0));
        run_vec(mk({nm, "_scan1"}, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, fc0, 0));
        run_vec(mk({nm, "_scan2"}, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, fc0, 0));
        run_vec(mk({nm, "_fail"},  1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, fc0 + 4'd1, 0));
        run_vec(mk({nm, "_after"}, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, fc0 + 4'd1, 0));
    endtask

    initial begin
        bus_if.id_req = 0; bus_if.id_in = 0; bus_if.pwd_req = 0; bus_if.pwd_in = 0;
        bus_if.reconfig = 0; bus_if.cfg_we = 0; bus_if.cfg_idx = 0; bus_if.cfg_id = 0; bus_if.cfg_pwd = 0;

        //                 name             rst ir id       pr pwd      rc cw idx cfg_id   cfg_pwd   ack idc pc idf pwf lk bsy fc ui
        tbl.push_back(mk("reset",           0, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cfg_wr0_1234",    1, 0, 16'h0,    0, 16'h0,    0, 1, 0, 16'h1234, 16'h5678, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cfg_ack_drop",    1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("id_req_1234",     1, 1, 16'h1234, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("id_hit_T2",       1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("pwd_req_5678",    1, 0, 16'h0,    1, 16'h5678, 0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("pass_checked",    1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("reconfig_clear",  1, 0, 16'h0,    0, 16'h0,    1, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idle",            1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cfg_wr2_4321",    1, 0, 16'h0,    0, 16'h0,    0, 1, 2, 16'h4321, 16'h1111, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cfg_wr0_4321",    1, 0, 16'h0,    0, 16'h0,    0, 1, 0, 16'h4321, 16'h2222, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("id_req_4321",     1, 1, 16'h4321, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("id_hit_low_idx",  1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("pwd_req_bad1",    1, 0, 16'h0,    1, 16'h0000, 0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("pwd_fail1",       1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk("pwd_req_bad2",    1, 0, 16'h0,    1, 16'h0000, 0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("pwd_fail2",       1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk("pwd_req_bad3",    1, 0, 16'h0,    1, 16'h0000, 0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk("lock_entry",      1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 1, 1, 0, 3, 0));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Lockout window: 19 more locked cycles with requests, config and reconfig all ignored,
        // then lockout drops on the 20th edge with the failure count cleared.
        for (int k = 1; k <= 20; k++) begin
            logic ir, pr, rc, cw;
            ir = (k == 3);
            pr = (k == 7);
            rc = (k == 6);
            cw = (k == 5);
            if (k < 20)
                run_vec(mk($sformatf("locked_%0d", k), 1, ir, 16'h4321, pr, 16'h2222, rc, cw, 1, 16'h7777, 16'h7777,
                           0, 0, 0, 0, 0, 1, 0, 3, 0));
            else
                run_vec(mk("lock_release", 1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

        // Unknown ID: id_fail at T+5. Then 7777, whose write was attempted while locked.
        scan_miss("miss_9999", 16'h9999, 4'd0);
        scan_miss("miss_7777", 16'h7777, 4'd1);

        // Config write colliding with an id_req edge is dropped: idx0 still holds 4321/2222.
        run_vec(mk("collide_req",     1, 1, 16'h4321, 0, 16'h0,    0, 1, 0, 16'h1234, 16'h5678, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        run_vec(mk("collide_hit",     1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 0, 2, 0));
        run_vec(mk("collide_pwd_req", 1, 0, 16'h0,    1, 16'h2222, 0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 1, 2, 0));
        run_vec(mk("collide_pass",    1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 1, 1, 0, 0, 0, 0, 0, 0));
        run_vec(mk("collide_reconfig",1, 0, 16'h0,    0, 16'h0,    1, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reconfig during the cycle that would match discards the match.
        run_vec(mk("rc_scan_req",     1, 1, 16'h4321, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 1, 0, 0));
        run_vec(mk("rc_scan_abort",   1, 0, 16'h0,    0, 16'h0,    1, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk("rc_scan_idle",    1, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Out-of-range index is not acknowledged.
        run_vec(mk("cfg_idx5_noack",  1, 0, 16'h0,    0, 16'h0,    0, 1, 5, 16'h5555, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-scan clears outputs and invalidates the table, so 4321 then misses.
        run_vec(mk("rst_scan_req",    1, 1, 16'h9999, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 1, 0, 0));
        run_vec(mk("rst_mid_scan",    0, 0, 16'h0,    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        scan_miss("post_rst_4321", 16'h4321, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
